mfp_eic_prio_core: RTL and testbench

Parametrised next-generation external interrupt controller core. It has configurable channel count, per-channel edge/level sensing, and per-channel programmable priority. A registered priority arbiter drives the MIPS EIC interface, and an explicit CPU acknowledge handshake controls the presented request. It sits behind the existing AHB-Lite register bridge, using the same simple read/write port style as mfp_eic_core.

---
 rtl/mfp_eic_prio_core.sv | 211 +++++++++++++++++++++
 tb/tb_mfp_eic_prio_core.sv | 195 +++++++++++++++++++
 2 files changed

// File: rtl/mfp_eic_prio_core.sv
// Prioritised external interrupt controller core driving the MIPS EIC interface.
// Optional preemption of the presented request: define MFP_EIC_PREEMPT_EN.
module mfp_eic_prio_core #(
  parameter int unsigned CHANNELS       = 32,
  parameter int unsigned SENSE_CHANNELS = 16,
  parameter int unsigned PRIO_W         = 3,
  parameter int unsigned ADDR_W         = 5
) (
  input  logic                CLK,
  input  logic                RESETn,
  input  logic [CHANNELS-1:0] signal,
  input  logic [ADDR_W-1:0]   read_addr,
  output logic [31:0]         read_data,
  input  logic [ADDR_W-1:0]   write_addr,
  input  logic [31:0]         write_data,
  input  logic                write_enable,
  input  logic                EIC_IAck,
  output logic [16:0]         EIC_Offset,
  output logic [3:0]          EIC_ShadowSet,
  output logic [7:0]          EIC_Interrupt,
  output logic [5:0]          EIC_Vector,
  output logic                EIC_Present
);

  localparam int NCh    = int'(CHANNELS);
  localparam int NSense = int'(SENSE_CHANNELS);
  localparam int SenseN = (NSense > 0) ? NSense : 1;

  typedef enum logic [1:0] {StIdle, StPresent, StGap} state_e;

  logic [CHANNELS-1:0] r_sync1, r_sync2, r_mask, r_flag;
  logic [SenseN-1:0]   r_prev;
  logic                r_en;
  logic [1:0]          r_sense [SenseN];
  logic [PRIO_W-1:0]   r_prio  [CHANNELS];
  logic [31:0]         r_rdata;
  state_e              r_state;
  logic [PRIO_W-1:0]   r_irq;
  logic [5:0]          r_vec;

  logic [CHANNELS-1:0] w_hw_set, w_flag_d, w_pend;
  logic [31:0]         w_rdata;
  logic [PRIO_W-1:0]   w_best_prio, w_irq_d;
  logic [5:0]          w_best_idx, w_vec_d;
  logic                w_cur_pend, w_ack;
  state_e              w_state_d;
  int                  w_wa, w_ra, w_vec_i;

  assign w_wa    = int'(write_addr);
  assign w_ra    = int'(read_addr);
  assign w_vec_i = int'(r_vec);

  // Synchroniser plus previous-value register for edge detection
  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_sync1 <= '0;
      r_sync2 <= '0;
      r_prev  <= '0;
    end else begin
      r_sync1 <= signal;
      r_sync2 <= r_sync1;
      r_prev  <= r_sync2[SenseN-1:0];
    end
  end

  always_comb begin
    w_hw_set = '0;
    for (int c = NSense; c < NCh; c++) begin
      w_hw_set[c] = r_sync2[c];
    end
    for (int s = 0; s < NSense; s++) begin
      case (r_sense[s])
        2'b01:   w_hw_set[s] = r_sync2[s] ^ r_prev[s];
        2'b10:   w_hw_set[s] = r_prev[s] & ~r_sync2[s];
        2'b11:   w_hw_set[s] = ~r_prev[s] & r_sync2[s];
        default: w_hw_set[s] = 1'b0;
      endcase
    end
  end

  // Software writes and ack-clear first; hardware set is OR-ed last so it always wins
  always_comb begin
    w_flag_d = r_flag;
    for (int c = 0; c < NCh; c++) begin
      if (write_enable && w_wa == 3 + c / 32) w_flag_d[c] = write_data[c % 32];
      if (write_enable && w_wa == 5 + c / 32 && write_data[c % 32]) w_flag_d[c] = 1'b1;
      if (write_enable && w_wa == 7 + c / 32 && write_data[c % 32]) w_flag_d[c] = 1'b0;
    end
    for (int s = 0; s < NSense; s++) begin
      if (w_ack && s == w_vec_i) w_flag_d[s] = 1'b0;
    end
    w_flag_d = w_flag_d | w_hw_set;
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_en    <= 1'b0;
      r_mask  <= '0;
      r_flag  <= '0;
      r_sense <= '{default: '0};
      r_prio  <= '{default: '0};
    end else begin
      r_flag <= w_flag_d;
      if (write_enable) begin
        if (w_wa == 0) r_en <= write_data[0];
        for (int c = 0; c < NCh; c++) begin
          if (w_wa == 1 + c / 32) r_mask[c] <= write_data[c % 32];
          if (w_wa == 16 + c / 8) r_prio[c] <= write_data[4 * (c % 8) +: PRIO_W];
        end
        for (int s = 0; s < NSense; s++) begin
          if (w_wa == 9 + s / 16) r_sense[s] <= write_data[2 * (s % 16) +: 2];
        end
      end
    end
  end

  always_comb begin
    w_rdata = '0;
    if (w_ra == 0) w_rdata[0] = r_en;
    for (int c = 0; c < NCh; c++) begin
      if (w_ra == 1 + c / 32) w_rdata[c % 32] = r_mask[c];
      if (w_ra == 3 + c / 32) w_rdata[c % 32] = r_flag[c];
      if (w_ra == 16 + c / 8) w_rdata[4 * (c % 8) +: PRIO_W] = r_prio[c];
    end
    for (int s = 0; s < NSense; s++) begin
      if (w_ra == 9 + s / 16) w_rdata[2 * (s % 16) +: 2] = r_sense[s];
    end
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) r_rdata <= '0;
    else         r_rdata <= w_rdata;
  end

  // Strict '>' while scanning upwards keeps the lowest index on a priority tie
  always_comb begin
    w_pend      = '0;
    w_best_prio = '0;
    w_best_idx  = '0;
    w_cur_pend  = 1'b0;
    for (int c = 0; c < NCh; c++) begin
      w_pend[c] = r_en & r_flag[c] & r_mask[c] & (|r_prio[c]);
      if (w_pend[c] && r_prio[c] > w_best_prio) begin
        w_best_prio = r_prio[c];
        w_best_idx  = 6'(c);
      end
      if (c == w_vec_i) w_cur_pend = w_pend[c];
    end
  end

  always_comb begin
    w_state_d = r_state;
    w_irq_d   = r_irq;
    w_vec_d   = r_vec;
    w_ack     = 1'b0;
    unique case (r_state)
      StIdle: begin
        w_irq_d = '0;
        w_vec_d = '0;
        if (|w_pend) begin
          w_state_d = StPresent;
          w_irq_d   = w_best_prio;
          w_vec_d   = w_best_idx;
        end
      end
      StPresent: begin
        if (!w_cur_pend) begin
          w_state_d = StIdle;
          w_irq_d   = '0;
          w_vec_d   = '0;
        end else if (EIC_IAck) begin
          w_ack     = 1'b1;
          w_state_d = StGap;
          w_irq_d   = '0;
          w_vec_d   = '0;
        end
`ifdef MFP_EIC_PREEMPT_EN
        else if (w_best_prio > r_irq) begin
          w_irq_d = w_best_prio;
          w_vec_d = w_best_idx;
        end
`endif
      end
      default: begin
        w_state_d = StIdle;
        w_irq_d   = '0;
        w_vec_d   = '0;
      end
    endcase
  end

  always_ff @(posedge CLK) begin
    if (!RESETn) begin
      r_state <= StIdle;
      r_irq   <= '0;
      r_vec   <= '0;
    end else begin
      r_state <= w_state_d;
      r_irq   <= w_irq_d;
      r_vec   <= w_vec_d;
    end
  end

  assign read_data     = r_rdata;
  assign EIC_Interrupt = {{(8 - PRIO_W){1'b0}}, r_irq};
  assign EIC_Vector    = r_vec;
  assign EIC_Offset    = {8'b0, r_vec, 3'b0};
  assign EIC_ShadowSet = 4'b0;
  assign EIC_Present   = 1'b1;

endmodule

// File: tb/tb_mfp_eic_prio_core.sv
// Directed self-checking bench for mfp_eic_prio_core (64 channels, default build).
module tb_mfp_eic_prio_core;

  logic        CLK = 1'b0;
  logic        RESETn = 1'b0;
  logic [63:0] signal = '0;
  logic [4:0]  read_addr = '0;
  logic [31:0] read_data;
  logic [4:0]  write_addr = '0;
  logic [31:0] write_data = '0;
  logic        write_enable = 1'b0;
  logic        EIC_IAck = 1'b0;
  logic [16:0] EIC_Offset;
  logic [3:0]  EIC_ShadowSet;
  logic [7:0]  EIC_Interrupt;
  logic [5:0]  EIC_Vector;
  logic        EIC_Present;

  int total = 0;
  int bad = 0;
  logic [31:0] d;

  always #5 CLK = ~CLK;

  mfp_eic_prio_core #(
    .CHANNELS      (64),
    .SENSE_CHANNELS(16),
    .PRIO_W        (3),
    .ADDR_W        (5)
  ) u_dut (
    .CLK          (CLK),
    .RESETn       (RESETn),
    .signal       (signal),
    .read_addr    (read_addr),
    .read_data    (read_data),
    .write_addr   (write_addr),
    .write_data   (write_data),
    .write_enable (write_enable),
    .EIC_IAck     (EIC_IAck),
    .EIC_Offset   (EIC_Offset),
    .EIC_ShadowSet(EIC_ShadowSet),
    .EIC_Interrupt(EIC_Interrupt),
    .EIC_Vector   (EIC_Vector),
    .EIC_Present  (EIC_Present)
  );

  task automatic tick();
    @(posedge CLK);
    #1;
  endtask

  task automatic wr(input int a, input logic [31:0] v);
    write_addr   = 5'(a);
    write_data   = v;
    write_enable = 1'b1;
    tick();
    write_enable = 1'b0;
  endtask

  task automatic rd(input int a, output logic [31:0] v);
    read_addr = 5'(a);
    tick();
    v = read_data;
  endtask

  task automatic ack();
    EIC_IAck = 1'b1;
    tick();
    EIC_IAck = 1'b0;
  endtask

  task automatic test_reset();
    RESETn = 1'b0;
    tick();
    tick();
    RESETn = 1'b1;
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL rst_rdata got=%0h want=0", read_data); end
    total++; if (EIC_Interrupt !== 8'h0) begin bad++; $display("FAIL rst_irq got=%0d want=0", EIC_Interrupt); end
    total++; if (EIC_Vector !== 6'h0) begin bad++; $display("FAIL rst_vec got=%0d want=0", EIC_Vector); end
    total++; if (EIC_Offset !== 17'h0) begin bad++; $display("FAIL rst_off got=%0h want=0", EIC_Offset); end
    total++; if (EIC_ShadowSet !== 4'h0) begin bad++; $display("FAIL rst_ss got=%0h want=0", EIC_ShadowSet); end
    total++; if (EIC_Present !== 1'b1) begin bad++; $display("FAIL rst_present got=%0b want=1", EIC_Present); end
  endtask

  task automatic test_priority();
    wr(9, 32'h5);
    wr(1, 32'h3);
    wr(16, 32'h21);
    signal[0] = 1'b1; tick(); signal[0] = 1'b0;
    repeat (4) tick();
    signal[1] = 1'b1; tick(); signal[1] = 1'b0;
    repeat (4) tick();
    rd(3, d);
    total++; if (d !== 32'h3) begin bad++; $display("FAIL prio_eifr got=%0h want=3", d); end
    total++; if (EIC_Interrupt !== 8'h0) begin bad++; $display("FAIL prio_disabled got=%0d want=0", EIC_Interrupt); end
    // Arm after both flags are up so both channels meet in one arbitration
    wr(0, 32'h1);
    total++; if (EIC_Interrupt !== 8'h0) begin bad++; $display("FAIL prio_latency got=%0d want=0", EIC_Interrupt); end
    tick();
    total++; if (EIC_Interrupt !== 8'd2) begin bad++; $display("FAIL prio_irq got=%0d want=2", EIC_Interrupt); end
    total++; if (EIC_Vector !== 6'd1) begin bad++; $display("FAIL prio_vec got=%0d want=1", EIC_Vector); end
    total++; if (EIC_Offset !== 17'h8) begin bad++; $display("FAIL prio_off got=%0h want=8", EIC_Offset); end
  endtask

  task automatic test_ack();
    ack();
    total++; if (EIC_Interrupt !== 8'h0) begin bad++; $display("FAIL ack_gap got=%0d want=0", EIC_Interrupt); end
    rd(3, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL ack_eifr got=%0h want=1", d); end
    total++; if (EIC_Interrupt !== 8'h0) begin bad++; $display("FAIL ack_idle got=%0d want=0", EIC_Interrupt); end
    tick();
    total++; if (EIC_Interrupt !== 8'd1) begin bad++; $display("FAIL ack_next_irq got=%0d want=1", EIC_Interrupt); end
    total++; if (EIC_Vector !== 6'd0) begin bad++; $display("FAIL ack_next_vec got=%0d want=0", EIC_Vector); end
    ack();
    tick();
    rd(3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL ack_clean got=%0h want=0", d); end
  endtask

  task automatic test_direct();
    wr(20, 32'h3);
    wr(2, 32'h1);
    signal[32] = 1'b1;
    repeat (3) tick();
    wr(8, 32'h1);
    rd(4, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL dir_held got=%0h want=1", d); end
    total++; if (EIC_Interrupt !== 8'd3) begin bad++; $display("FAIL dir_irq got=%0d want=3", EIC_Interrupt); end
    total++; if (EIC_Vector !== 6'd32) begin bad++; $display("FAIL dir_vec got=%0d want=32", EIC_Vector); end
    signal[32] = 1'b0;
    repeat (3) tick();
    wr(8, 32'h1);
    rd(4, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL dir_clr got=%0h want=0", d); end
    total++; if (EIC_Interrupt !== 8'h0) begin bad++; $display("FAIL dir_withdraw got=%0d want=0", EIC_Interrupt); end
  endtask

  task automatic test_set_mask();
    wr(16, 32'h521);
    wr(5, 32'h4);
    rd(3, d);
    total++; if (d !== 32'h4) begin bad++; $display("FAIL set_eifr got=%0h want=4", d); end
    total++; if (EIC_Interrupt !== 8'h0) begin bad++; $display("FAIL set_masked got=%0d want=0", EIC_Interrupt); end
    rd(5, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL set_eifrs_rd got=%0h want=0", d); end
    wr(1, 32'h7);
    tick();
    total++; if (EIC_Interrupt !== 8'd5) begin bad++; $display("FAIL set_irq got=%0d want=5", EIC_Interrupt); end
    total++; if (EIC_Vector !== 6'd2) begin bad++; $display("FAIL set_vec got=%0d want=2", EIC_Vector); end
    total++; if (EIC_Offset !== 17'h10) begin bad++; $display("FAIL set_off got=%0h want=10", EIC_Offset); end
    ack();
    rd(3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL set_ackclr got=%0h want=0", d); end
  endtask

  task automatic test_set_beats_clear();
    wr(9, 32'h7);
    signal[0] = 1'b1;
    tick();
    tick();
    // Rising edge lands on the same clock as the EIFRC write
    wr(7, 32'h1);
    rd(3, d);
    total++; if (d !== 32'h1) begin bad++; $display("FAIL race_flag got=%0h want=1", d); end
    total++; if (EIC_Interrupt !== 8'd1) begin bad++; $display("FAIL race_irq got=%0d want=1", EIC_Interrupt); end
  endtask

  task automatic test_reset_mid();
    RESETn = 1'b0;
    tick();
    RESETn = 1'b1;
    total++; if (EIC_Interrupt !== 8'h0) begin bad++; $display("FAIL mrst_irq got=%0d want=0", EIC_Interrupt); end
    total++; if (EIC_Vector !== 6'h0) begin bad++; $display("FAIL mrst_vec got=%0d want=0", EIC_Vector); end
    total++; if (EIC_Offset !== 17'h0) begin bad++; $display("FAIL mrst_off got=%0h want=0", EIC_Offset); end
    total++; if (EIC_Present !== 1'b1) begin bad++; $display("FAIL mrst_present got=%0b want=1", EIC_Present); end
    total++; if (read_data !== 32'h0) begin bad++; $display("FAIL mrst_rdata got=%0h want=0", read_data); end
    rd(3, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mrst_eifr got=%0h want=0", d); end
    rd(16, d);
    total++; if (d !== 32'h0) begin bad++; $display("FAIL mrst_eipr got=%0h want=0", d); end
  endtask

  initial begin
    test_reset();
    test_priority();
    test_ack();
    test_direct();
    test_set_mask();
    test_set_beats_clear();
    test_reset_mid();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
